// File: rtl/i2c_cmd_sequencer.sv
// Wishbone master sequencing OpenCores I2C core register accesses: prescaler/enable
// setup after reset, then single-byte register write/read commands with status.
module i2c_cmd_sequencer #(
  parameter logic [15:0] PRESCALE   = 16'd99,
  parameter logic [15:0] POLL_LIMIT = 16'd50000
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  output logic       m_we_o,
  output logic       m_stb_o,
  input  logic       m_ack_i
);

  localparam logic [3:0] S_INIT  = 4'd0;
  localparam logic [3:0] S_IDLE  = 4'd1;
  localparam logic [3:0] S_TXR   = 4'd2;
  localparam logic [3:0] S_CR    = 4'd3;
  localparam logic [3:0] S_POLL  = 4'd4;
  localparam logic [3:0] S_STOPW = 4'd5;
  localparam logic [3:0] S_STOPP = 4'd6;
  localparam logic [3:0] S_RXR   = 4'd7;
  localparam logic [3:0] S_RESP  = 4'd8;

  localparam logic [2:0] A_TXR = 3'd3;
  localparam logic [2:0] A_CR  = 3'd4;

  logic [3:0]  state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] poll_q, poll_d;
  logic        rd_q, rd_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  err_q, err_d;
  logic        stb_q, stb_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic        we_q, we_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;

  logic        req_go, req_we, ack, fin;
  logic [2:0]  req_adr;
  logic [7:0]  req_dat, txr_val, cr_val, fin_data;
  logic [1:0]  fin_err;
  logic [15:0] poll_inc;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    poll_d      = poll_q;
    rd_d        = rd_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    stb_d       = stb_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_go      = 1'b0;
    req_we      = 1'b0;
    req_adr     = 3'd0;
    req_dat     = 8'h00;
    fin         = 1'b0;
    fin_err     = 2'd0;
    fin_data    = 8'h00;

    // Byte step table; step 3 exists only for reads and has no TXR write.
    case (step_q)
      2'd0:    begin txr_val = {dev_q, 1'b0}; cr_val = 8'h90; end
      2'd1:    begin txr_val = reg_q;         cr_val = 8'h10; end
      2'd2:    begin
        txr_val = rd_q ? {dev_q, 1'b1} : wdata_q;
        cr_val  = rd_q ? 8'h90 : 8'h50;
      end
      default: begin txr_val = 8'h00;         cr_val = 8'h68; end
    endcase

    case (state_q)
      S_INIT: begin
        req_go  = 1'b1;
        req_we  = 1'b1;
        req_adr = {1'b0, step_q};
        req_dat = (step_q == 2'd0) ? PRESCALE[7:0] :
                  (step_q == 2'd1) ? PRESCALE[15:8] : 8'h80;
      end
      S_TXR:   begin req_go = 1'b1; req_we = 1'b1; req_adr = A_TXR; req_dat = txr_val; end
      S_CR:    begin req_go = 1'b1; req_we = 1'b1; req_adr = A_CR;  req_dat = cr_val;  end
      S_POLL,
      S_STOPP: begin req_go = 1'b1; req_adr = A_CR; end
      S_STOPW: begin req_go = 1'b1; req_we = 1'b1; req_adr = A_CR;  req_dat = 8'h40;   end
      S_RXR:   begin req_go = 1'b1; req_adr = A_TXR; end
      default: ;
    endcase

    // Launch only from a dropped strobe with ack low, which forces the idle gap.
    ack = stb_q & m_ack_i;
    if (req_go && !stb_q && !m_ack_i) begin
      stb_d = 1'b1;
      adr_d = req_adr;
      dat_d = req_dat;
      we_d  = req_we;
    end
    if (ack) stb_d = 1'b0;

    poll_inc = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;

    case (state_q)
      S_INIT: if (ack) begin
        if (step_q == 2'd2) begin
          state_d = S_IDLE;
          step_d  = 2'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      S_IDLE: if (cmd_valid) begin
        rd_d    = cmd_rd;
        dev_d   = cmd_dev;
        reg_d   = cmd_reg;
        wdata_d = cmd_wdata;
        step_d  = 2'd0;
        err_d   = 2'd0;
        state_d = S_TXR;
      end
      S_TXR: if (ack) state_d = S_CR;
      S_CR: if (ack) begin
        state_d = S_POLL;
        poll_d  = 16'd0;
      end
      S_POLL: if (ack) begin
        poll_d = poll_inc;
        if (m_dat_i[5]) begin
          fin     = 1'b1;
          fin_err = 2'd2;
        end else if (m_dat_i[1]) begin
          if (poll_inc >= POLL_LIMIT) begin
            err_d   = 2'd3;
            state_d = S_STOPW;
          end
        end else if (rd_q && step_q == 2'd3) begin
          state_d = S_RXR;
        end else if (m_dat_i[7]) begin
          err_d   = 2'd1;
          state_d = S_STOPW;
        end else if (!rd_q && step_q == 2'd2) begin
          fin = 1'b1;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = (rd_q && step_q == 2'd2) ? S_CR : S_TXR;
        end
      end
      S_STOPW: if (ack) begin
        state_d = S_STOPP;
        poll_d  = 16'd0;
      end
      S_STOPP: if (ack) begin
        poll_d = poll_inc;
        if (!m_dat_i[6]) begin
          fin     = 1'b1;
          fin_err = err_q;
        end else if (poll_inc >= POLL_LIMIT) begin
          fin     = 1'b1;
          fin_err = 2'd3;
        end
      end
      S_RXR: if (ack) begin
        fin      = 1'b1;
        fin_data = m_dat_i;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    if (fin) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = fin_err;
      rsp_rdata_d = (fin_err == 2'd0) ? fin_data : 8'h00;
      state_d     = S_RESP;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q     <= S_INIT;
      step_q      <= 2'd0;
      poll_q      <= 16'd0;
      rd_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'h00;
      wdata_q     <= 8'h00;
      err_q       <= 2'd0;
      stb_q       <= 1'b0;
      adr_q       <= 3'd0;
      dat_q       <= 8'h00;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      poll_q      <= poll_d;
      rd_q        <= rd_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      stb_q       <= stb_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign m_stb_o   = stb_q;
  assign m_adr_o   = adr_q;
  assign m_dat_o   = dat_q;
  assign m_we_o    = we_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: scripted I2C core model, transaction-level expected
// access/response queue, bus-protocol checks, and literal spot checks.
module tb_i2c_cmd_sequencer;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       cmd_valid, cmd_ready, cmd_rd;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] m_adr_o;
  logic [7:0] m_dat_o, m_dat_i;
  logic       m_we_o, m_stb_o, m_ack_i;

  always #5 wb_clk_i = ~wb_clk_i;

  i2c_cmd_sequencer #(.PRESCALE(16'd99), .POLL_LIMIT(16'd8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i)
  );

  // kind: 0 core write, 1 core read, 2 response
  typedef struct {
    int         kind;
    logic [2:0] adr;
    logic [7:0] dat;
    logic [1:0] err;
  } exp_t;

  localparam int S_NORM = 0, S_NACK = 1, S_TMO = 2, S_AL = 3;

  exp_t        q[$];
  int          vectors = 0, miscompares = 0;
  int          scen = S_NORM, nack_byte = 0, max_dly = 0;
  logic [7:0]  rxr = 8'h00;
  int          byte_idx = -1, poll_n = 0, rsp_cnt = 0, sr_reads = 0;
  logic [7:0]  last_cr = 8'h00;
  logic [7:0]  txr_log[$];
  logic [10:0] wr_log[$];
  logic [1:0]  last_err = 2'd0;
  logic [7:0]  last_rdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [2:0] a, input logic [7:0] d, input logic [1:0] e);
    exp_t x;
    x.kind = k; x.adr = a; x.dat = d; x.err = e;
    q.push_back(x);
  endtask

  task automatic push_init();
    push(0, 3'd0, 8'h63, 2'd0);
    push(0, 3'd1, 8'h00, 2'd0);
    push(0, 3'd2, 8'h80, 2'd0);
  endtask

  // Expected traffic for one command given the scripted core behaviour:
  // every byte costs two SR polls (busy, then done) unless the scenario says otherwise.
  task automatic plan(input bit rd, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    logic [7:0] txb[4];
    logic [7:0] crb[4];
    int n;
    txb[0] = {dev, 1'b0}; crb[0] = 8'h90;
    txb[1] = rg;          crb[1] = 8'h10;
    txb[2] = rd ? {dev, 1'b1} : wd;
    crb[2] = rd ? 8'h90 : 8'h50;
    txb[3] = 8'h00;       crb[3] = 8'h68;
    n = rd ? 4 : 3;
    for (int i = 0; i < n; i++) begin
      if (i < 3) push(0, 3'd3, txb[i], 2'd0);
      push(0, 3'd4, crb[i], 2'd0);
      if (scen == S_TMO) begin
        repeat (8) push(1, 3'd4, 8'h00, 2'd0);
        push(0, 3'd4, 8'h40, 2'd0);
        repeat (8) push(1, 3'd4, 8'h00, 2'd0);
        push(2, 3'd0, 8'h00, 2'd3);
        return;
      end
      push(1, 3'd4, 8'h00, 2'd0);
      push(1, 3'd4, 8'h00, 2'd0);
      if (scen == S_AL) begin
        push(2, 3'd0, 8'h00, 2'd2);
        return;
      end
      if (scen == S_NACK && i == nack_byte) begin
        push(0, 3'd4, 8'h40, 2'd0);
        push(1, 3'd4, 8'h00, 2'd0);
        push(1, 3'd4, 8'h00, 2'd0);
        push(2, 3'd0, 8'h00, 2'd1);
        return;
      end
    end
    if (rd) begin
      push(1, 3'd3, 8'h00, 2'd0);
      push(2, 3'd0, rxr, 2'd0);
    end else begin
      push(2, 3'd0, 8'h00, 2'd0);
    end
  endtask

  function automatic logic [7:0] sr_value();
    if (scen == S_TMO) return 8'h42;
    if (scen == S_AL && byte_idx == 0 && poll_n == 2) return 8'h20;
    if (last_cr == 8'h40) return (poll_n == 1) ? 8'h40 : 8'h00;
    if (poll_n == 1) return 8'h42;
    if (last_cr == 8'h68) return 8'hC0;
    return (scen == S_NACK && byte_idx == nack_byte) ? 8'hC0 : 8'h40;
  endfunction

  // Core model + compare process, all on the falling edge.
  initial begin
    int         dly;
    bit         acc, p_valid, p_stb, p_we, p_rsp;
    logic [2:0] p_adr;
    logic [7:0] p_dat;
    exp_t       e;
    dly = 0; acc = 0; p_valid = 0; p_stb = 0; p_we = 0; p_rsp = 0;
    p_adr = 3'd0; p_dat = 8'h00;
    m_ack_i = 1'b0;
    m_dat_i = 8'h00;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i && p_valid) begin
        if (p_stb && m_ack_i) begin
          chk("stb drop after ack", {31'd0, m_stb_o}, 32'd0);
        end else if (p_stb) begin
          chk("stb held until ack", {20'd0, m_stb_o, m_we_o, m_adr_o, m_dat_o},
              {20'd0, 1'b1, p_we, p_adr, p_dat});
        end else if (m_stb_o && m_ack_i) begin
          chk("access issued during ack", 32'd1, 32'd0);
        end
        if (!rsp_valid)
          chk("rsp hold", {22'd0, rsp_err, rsp_rdata}, {22'd0, last_err, last_rdata});
        if (p_rsp && !rsp_valid)
          chk("ready after rsp", {31'd0, cmd_ready}, 32'd1);
        if (p_rsp && rsp_valid)
          chk("rsp_valid width", 32'd2, 32'd1);
      end
      p_valid = wb_rst_i; p_stb = m_stb_o; p_we = m_we_o; p_adr = m_adr_o; p_dat = m_dat_o;
      p_rsp = wb_rst_i && rsp_valid;

      if (!wb_rst_i) begin
        m_ack_i = 1'b0;
        acc = 0;
      end else if (m_ack_i) begin
        m_ack_i = 1'b0;
      end else if (m_stb_o) begin
        if (!acc) begin
          acc = 1;
          dly = $urandom_range(0, max_dly);
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL access: got we=%0b adr=%0d dat=%02h, expected none",
                     m_we_o, m_adr_o, m_dat_o);
          end else begin
            e = q.pop_front();
            if (e.kind != (m_we_o ? 0 : 1) || e.adr != m_adr_o || (m_we_o && e.dat != m_dat_o)) begin
              miscompares++;
              $display("FAIL access: got we=%0b adr=%0d dat=%02h, expected kind=%0d adr=%0d dat=%02h",
                       m_we_o, m_adr_o, m_dat_o, e.kind, e.adr, e.dat);
            end
          end
        end
        if (dly == 0) begin
          if (m_we_o) begin
            wr_log.push_back({m_adr_o, m_dat_o});
            if (m_adr_o == 3'd3) txr_log.push_back(m_dat_o);
            if (m_adr_o == 3'd4) begin
              last_cr = m_dat_o;
              poll_n  = 0;
              if (m_dat_o[4] || m_dat_o[5]) byte_idx++;
            end
          end else if (m_adr_o == 3'd4) begin
            poll_n++;
            sr_reads++;
            m_dat_i = sr_value();
          end else begin
            m_dat_i = rxr;
          end
          m_ack_i = 1'b1;
          acc = 0;
        end else begin
          dly--;
        end
      end else begin
        acc = 0;
      end

      if (wb_rst_i && rsp_valid) begin
        vectors++;
        chk("ready low at rsp", {31'd0, cmd_ready}, 32'd0);
        if (q.size() == 0 || q[0].kind != 2) begin
          miscompares++;
          $display("FAIL response: got err=%0d rdata=%02h with accesses still expected",
                   rsp_err, rsp_rdata);
          q.delete();
        end else begin
          e = q.pop_front();
          if (e.err != rsp_err || e.dat != rsp_rdata) begin
            miscompares++;
            $display("FAIL response: got err=%0d rdata=%02h expected err=%0d rdata=%02h",
                     rsp_err, rsp_rdata, e.err, e.dat);
          end
        end
        last_err   = rsp_err;
        last_rdata = rsp_rdata;
        byte_idx   = -1;
        rsp_cnt++;
      end
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge wb_clk_i);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("cmd_ready timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge wb_clk_i);
      if (rsp_cnt >= target) begin ok = 1; break; end
    end
    if (!ok) chk("rsp timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input bit rd, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    wait_ready();
    cmd_valid = 1'b1; cmd_rd = rd; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_dev = 7'd0; cmd_reg = 8'h00; cmd_wdata = 8'h00;
  endtask

  task automatic run_cmd(input bit rd, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    int start;
    txr_log.delete(); wr_log.delete(); sr_reads = 0;
    plan(rd, dev, rg, wd);
    start = rsp_cnt;
    issue(rd, dev, rg, wd);
    wait_rsp(start + 1);
    chk("queue drained", q.size(), 32'd0);
  endtask

  initial begin
    int start;
    wb_rst_i = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0;
    cmd_dev = 7'd0; cmd_reg = 8'h00; cmd_wdata = 8'h00;

    push_init();
    repeat (3) @(negedge wb_clk_i);
    chk("reset outputs", {7'd0, m_stb_o, m_we_o, m_adr_o, m_dat_o, cmd_ready, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    @(posedge wb_clk_i); #2 wb_rst_i = 1'b1;
    wait_ready();
    chk("init write count", wr_log.size(), 32'd3);
    chk("init wr0", {21'd0, wr_log[0]}, {21'd0, 3'd0, 8'h63});
    chk("init wr1", {21'd0, wr_log[1]}, {21'd0, 3'd1, 8'h00});
    chk("init wr2", {21'd0, wr_log[2]}, {21'd0, 3'd2, 8'h80});
    chk("init queue", q.size(), 32'd0);

    scen = S_NORM;
    run_cmd(1'b0, 7'h1A, 8'h05, 8'hA5);
    chk("write txr count", txr_log.size(), 32'd3);
    chk("write txr0", {24'd0, txr_log[0]}, 32'h34);
    chk("write txr1", {24'd0, txr_log[1]}, 32'h05);
    chk("write txr2", {24'd0, txr_log[2]}, 32'hA5);
    chk("write err", {30'd0, last_err}, 32'd0);

    rxr = 8'h3C;
    run_cmd(1'b1, 7'h1A, 8'h0F, 8'h77);
    chk("read txr2", {24'd0, txr_log[2]}, 32'h35);
    chk("read rdata", {24'd0, last_rdata}, 32'h3C);
    chk("read err", {30'd0, last_err}, 32'd0);

    scen = S_NACK; nack_byte = 0;
    run_cmd(1'b0, 7'h1A, 8'h05, 8'hA5);
    chk("nack txr count", txr_log.size(), 32'd1);
    chk("nack err", {30'd0, last_err}, 32'd1);

    scen = S_TMO;
    run_cmd(1'b0, 7'h1A, 8'h05, 8'hA5);
    chk("timeout sr reads", sr_reads, 32'd16);
    chk("timeout err", {30'd0, last_err}, 32'd3);

    scen = S_AL;
    run_cmd(1'b0, 7'h1A, 8'h05, 8'hA5);
    chk("al sr reads", sr_reads, 32'd2);
    chk("al writes (no stop)", wr_log.size(), 32'd2);
    chk("al err", {30'd0, last_err}, 32'd2);

    scen = S_NACK; nack_byte = 2; rxr = 8'h99;
    run_cmd(1'b1, 7'h1A, 8'h0F, 8'h00);
    chk("read nack err", {30'd0, last_err}, 32'd1);
    chk("read nack rdata", {24'd0, last_rdata}, 32'h00);

    // Reset while polling: abort without a response, then INIT replays.
    scen = S_NORM;
    sr_reads = 0;
    plan(1'b0, 7'h2B, 8'h11, 8'h22);
    start = rsp_cnt;
    issue(1'b0, 7'h2B, 8'h11, 8'h22);
    for (int i = 0; i < 500 && sr_reads < 1; i++) @(negedge wb_clk_i);
    chk("reached poll", {31'd0, sr_reads >= 1}, 32'd1);
    @(posedge wb_clk_i); #2;
    wb_rst_i = 1'b0;
    q.delete(); last_err = 2'd0; last_rdata = 8'h00; byte_idx = -1; last_cr = 8'h00;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("mid reset outputs", {7'd0, m_stb_o, m_we_o, m_adr_o, m_dat_o, cmd_ready, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    push_init();
    wr_log.delete();
    @(posedge wb_clk_i); #2 wb_rst_i = 1'b1;
    wait_ready();
    chk("no rsp after reset", rsp_cnt, start);
    chk("init replay count", wr_log.size(), 32'd3);
    chk("init replay queue", q.size(), 32'd0);

    // Randomised ack latency.
    max_dly = 5;
    rxr = 8'hD2;
    run_cmd(1'b0, 7'h50, 8'h80, 8'h01);
    run_cmd(1'b1, 7'h7F, 8'hFF, 8'h00);
    chk("slow read rdata", {24'd0, last_rdata}, 32'hD2);

    // Command held valid across the response is accepted a second time.
    plan(1'b0, 7'h33, 8'h44, 8'h55);
    plan(1'b0, 7'h33, 8'h44, 8'h55);
    start = rsp_cnt;
    wait_ready();
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_dev = 7'h33; cmd_reg = 8'h44; cmd_wdata = 8'h55;
    wait_rsp(start + 1);
    wait_ready();
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    wait_rsp(start + 2);
    repeat (20) @(negedge wb_clk_i);
    chk("held cmd responses", rsp_cnt - start, 32'd2);
    chk("held cmd queue", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
